// File: rtl/jtframe_lfbuf_ddr_line.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_lfbuf_ddr_line
// Purpose  : Double-buffered object line buffer and line sequencer on the game
//            side of the DDR line-frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_lfbuf_ddr_line #(
    parameter int              HW      = 9,
    parameter int              VW      = 8,
    parameter int              DW      = 16,
    parameter logic [VW-1:0]   VLAST   = VW'(239),
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs,
    output logic          ln_hs,
    output logic [VW-1:0] ln_v,
    input  logic [HW-1:0] ln_addr,
    input  logic [DW-1:0] ln_data,
    input  logic          ln_we,
    input  logic          ln_done,
    output logic          ctl_done,
    input  logic          line,
    input  logic [HW-1:0] fb_addr,
    output logic [DW-1:0] fb_din,
    input  logic          fb_clr,
    input  logic          fb_done
);

    localparam int C_DEPTH = 2 ** (HW + 1);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        START   = 2'd1,
        DRAW    = 2'd2,
        HAND    = 2'd3
    } state_t;

    logic [DW-1:0] r_mem [0:C_DEPTH-1];
    state_t        r_st;
    state_t        w_st_nxt;
    logic          r_vs_l;
    logic          r_done_l;
    logic [VW-1:0] w_v_nxt;
    logic          w_hs_nxt;
    logic          w_cd_nxt;
    logic          w_vs_rise;
    logic          w_done_rise;
    logic          w_game_we;

    assign w_vs_rise   = vs & ~r_vs_l;
    assign w_done_rise = ln_done & ~r_done_l;
    assign w_game_we   = ln_we && (r_st == DRAW);

    // The two ports always target opposite halves, so both writes may land in one cycle
    always_ff @(posedge clk) begin
        if (w_game_we) begin
            r_mem[{line, ln_addr}] <= ln_data;
        end
        if (fb_clr) begin
            r_mem[{~line, fb_addr}] <= CLR_VAL;
        end
    end

    assign fb_din = r_mem[{~line, fb_addr}];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st     <= WAIT_VS;
            r_vs_l   <= 1'b0;
            r_done_l <= 1'b0;
            ln_hs    <= 1'b0;
            ln_v     <= '0;
            ctl_done <= 1'b0;
        end else begin
            r_st     <= w_st_nxt;
            r_vs_l   <= vs;
            r_done_l <= ln_done;
            ln_hs    <= w_hs_nxt;
            ln_v     <= w_v_nxt;
            ctl_done <= w_cd_nxt;
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        w_v_nxt  = ln_v;
        w_hs_nxt = 1'b0;
        w_cd_nxt = ctl_done;
        if (r_st != WAIT_VS && w_vs_rise) begin
            // A new frame aborts whatever line is in flight
            w_st_nxt = START;
            w_v_nxt  = '0;
            w_cd_nxt = 1'b0;
        end else begin
            case (r_st)
                WAIT_VS: begin
                    if (w_vs_rise) begin
                        w_v_nxt  = '0;
                        w_st_nxt = START;
                    end
                end
                START: begin
                    if (!fb_clr) begin
                        w_hs_nxt = 1'b1;
                        w_st_nxt = DRAW;
                    end
                end
                DRAW: begin
                    if (w_done_rise) begin
                        w_cd_nxt = 1'b1;
                        w_st_nxt = HAND;
                    end
                end
                HAND: begin
                    if (fb_done) begin
                        w_cd_nxt = 1'b0;
                        if (ln_v == VLAST) begin
                            w_st_nxt = WAIT_VS;
                        end else begin
                            w_v_nxt  = ln_v + 1'b1;
                            w_st_nxt = START;
                        end
                    end
                end
                default: w_st_nxt = WAIT_VS;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_lfbuf_ddr_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_lfbuf_ddr_line
// Purpose  : Directed self-checking bench for the DDR line buffer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_lfbuf_ddr_line;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs;
    logic        ln_hs;
    logic [7:0]  ln_v;
    logic [8:0]  ln_addr;
    logic [15:0] ln_data;
    logic        ln_we;
    logic        ln_done;
    logic        ctl_done;
    logic        line;
    logic [8:0]  fb_addr;
    logic [15:0] fb_din;
    logic        fb_clr;
    logic        fb_done;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    jtframe_lfbuf_ddr_line #(
        .HW(9), .VW(8), .DW(16), .VLAST(8'd239), .CLR_VAL(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vs(vs), .ln_hs(ln_hs), .ln_v(ln_v),
        .ln_addr(ln_addr), .ln_data(ln_data), .ln_we(ln_we), .ln_done(ln_done),
        .ctl_done(ctl_done), .line(line), .fb_addr(fb_addr), .fb_din(fb_din),
        .fb_clr(fb_clr), .fb_done(fb_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ln_hs) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic        vs;
        logic        we;
        logic [8:0]  addr;
        logic [15:0] data;
        logic        done;
        logic        line;
        logic [8:0]  fa;
        logic        clr;
        logic        fdone;
        logic        chk_din;
        logic [15:0] exp_din;
        logic        e_hs;
        logic [7:0]  e_v;
        logic        e_cd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n = 1'b0; vs = 1'b0; ln_addr = '0; ln_data = '0; ln_we = 1'b0;
        ln_done = 1'b0; line = 1'b0; fb_addr = '0; fb_clr = 1'b0; fb_done = 1'b0;

        vecs[0] = '{we:1'b1, addr:9'd3, data:16'hFFFF, default:'0};
        vecs[1] = '{vs:1'b1, default:'0};
        vecs[2] = '{vs:1'b1, done:1'b1, e_hs:1'b1, default:'0};
        vecs[3] = '{we:1'b1, addr:9'd5, data:16'h1234, default:'0};
        vecs[4] = '{done:1'b1, e_cd:1'b1, default:'0};
        vecs[5] = '{done:1'b1, e_cd:1'b1, default:'0};
        vecs[6] = '{line:1'b1, fdone:1'b1, e_v:8'd1, default:'0};
        vecs[7] = '{line:1'b1, fa:9'd5, chk_din:1'b1, exp_din:16'h1234,
                    e_hs:1'b1, e_v:8'd1, default:'0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs", ln_hs, 0);
        chk("rst_v", ln_v, 0);
        chk("rst_cd", ctl_done, 0);
        rst_n = 1'b1;

        // Start of frame, first line draw and handoff
        for (int i = 0; i < 8; i++) begin
            vs = vecs[i].vs; ln_we = vecs[i].we; ln_addr = vecs[i].addr;
            ln_data = vecs[i].data; ln_done = vecs[i].done; line = vecs[i].line;
            fb_addr = vecs[i].fa; fb_clr = vecs[i].clr; fb_done = vecs[i].fdone;
            #1;
            if (vecs[i].chk_din) chk($sformatf("vec%0d_din", i), fb_din, vecs[i].exp_din);
            cyc();
            chk($sformatf("vec%0d_hs", i), ln_hs, vecs[i].e_hs);
            chk($sformatf("vec%0d_v", i), ln_v, vecs[i].e_v);
            chk($sformatf("vec%0d_cd", i), ctl_done, vecs[i].e_cd);
        end
        ln_we = 1'b0; ln_done = 1'b0; fb_done = 1'b0; fb_addr = '0;

        // Finish line 1, move to line 2 drawing into half 0
        ln_done = 1'b1; cyc(); ln_done = 1'b0;
        chk("l1_cd", ctl_done, 1);
        fb_done = 1'b1; line = 1'b0; cyc(); fb_done = 1'b0;
        chk("l2_v", ln_v, 2);
        chk("l2_cd", ctl_done, 0);
        cyc();
        chk("l2_hs", ln_hs, 1);

        // Clear half 1 while the game writes half 0 and completes its line
        for (int i = 0; i < 512; i++) begin
            fb_clr = 1'b1; fb_addr = 9'(i);
            ln_we = (i == 100); ln_addr = 9'd7; ln_data = 16'hBEEF;
            ln_done = (i == 200);
            cyc();
            if (i == 200) chk("clr_cd", ctl_done, 1);
        end
        fb_clr = 1'b0; ln_we = 1'b0; ln_done = 1'b0;
        line = 1'b0;
        for (int i = 0; i < 512; i++) begin
            fb_addr = 9'(i);
            #1;
            chk($sformatf("clr_h1_%0d", i), fb_din, 16'h0000);
        end
        line = 1'b1;
        fb_addr = 9'd7; #1;
        chk("h0_7", fb_din, 16'hBEEF);
        fb_addr = 9'd5; #1;
        chk("h0_5", fb_din, 16'h1234);

        // Full frame of 240 lines
        vs = 1'b1; cyc(); vs = 1'b0;
        base = hs_cnt;
        for (int l = 0; l < 240; l++) begin
            n = 0;
            while (!ln_hs && n < 8) begin
                cyc();
                n++;
            end
            chk($sformatf("frame_hs_%0d", l), ln_hs, 1);
            chk($sformatf("frame_v_%0d", l), ln_v, l);
            ln_done = 1'b1; cyc(); ln_done = 1'b0; cyc();
            fb_done = 1'b1; line = ~line; cyc(); fb_done = 1'b0;
        end
        repeat (20) cyc();
        chk("frame_hs_cnt", hs_cnt - base, 240);
        chk("frame_end_v", ln_v, 239);
        chk("frame_end_cd", ctl_done, 0);

        // Writes and done edges in WAIT_VS are ignored
        line = 1'b1; ln_we = 1'b1; ln_addr = 9'd3; ln_data = 16'hFFFF; ln_done = 1'b1;
        cyc();
        ln_we = 1'b0; ln_done = 1'b0;
        chk("wvs_cd", ctl_done, 0);
        chk("wvs_hs", ln_hs, 0);
        line = 1'b0; fb_addr = 9'd3; #1;
        chk("wvs_ram", fb_din, 16'h0000);

        // START holds while a clear is in progress
        vs = 1'b1; cyc(); vs = 1'b0; fb_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("clr_hold_%0d", i), ln_hs, 0);
        end
        fb_clr = 1'b0; cyc();
        chk("clr_rel_hs", ln_hs, 1);
        chk("clr_rel_v", ln_v, 0);

        // Abort from HAND with simultaneous fb_done
        ln_done = 1'b1; cyc(); ln_done = 1'b0;
        fb_done = 1'b1; line = ~line; cyc(); fb_done = 1'b0;
        chk("ab_v1", ln_v, 1);
        cyc();
        chk("ab_hs1", ln_hs, 1);
        ln_done = 1'b1; cyc(); ln_done = 1'b0; cyc();
        chk("ab_hand_cd", ctl_done, 1);
        vs = 1'b1; fb_done = 1'b1; cyc(); vs = 1'b0; fb_done = 1'b0;
        chk("ab_cd", ctl_done, 0);
        chk("ab_v", ln_v, 0);
        cyc();
        chk("ab_hs", ln_hs, 1);
        chk("ab_hs_v", ln_v, 0);
        fb_done = 1'b1; cyc(); fb_done = 1'b0;
        chk("ab_late_fd_v", ln_v, 0);
        cyc();
        chk("ab_late_v", ln_v, 0);
        chk("ab_late_cd", ctl_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
